// File: rtl/matrix_stream_loader.sv
// Double-buffered stream-to-parallel loader for the PxP matrix multiplier.
// Collects A then B row-major, publishes the pair once the slot frees up.
module matrix_stream_loader #(
  parameter int N = 32,
  parameter int Q = 18,
  parameter int P = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [N-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [P*P*N-1:0]    A_out,
  output logic [P*P*N-1:0]    B_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic [7:0]          err_count
);

  localparam int E  = P * P;
  localparam int KW = (E > 1) ? $clog2(E) : 1;
  localparam int W  = E * N;
  localparam logic [KW-1:0] K_END = KW'(E - 1);

  if (Q >= N) begin : g_q_chk
    $error("Q must be smaller than N");
  end

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   sh_a_q, sh_a_d;
  logic [W-1:0]   sh_b_q, sh_b_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           ov_q, ov_d;
  logic           fe_q, fe_d;
  logic [7:0]     ec_q, ec_d;

  logic xfer;
  logic k_end;
  logic frame_bad;
  logic reload;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL_A: begin
        if (xfer && !frame_bad && k_end) state_d = FILL_B;
      end
      FILL_B: begin
        if (xfer && frame_bad) state_d = FILL_A;
        else if (xfer && k_end) state_d = HOLD;
      end
      HOLD: begin
        if (reload) state_d = FILL_A;
      end
      default: state_d = FILL_A;
    endcase
  end

  // in_last must be high exactly on the last B element, low everywhere else
  always_comb begin
    in_ready  = (state_q != HOLD);
    xfer      = in_valid && in_ready;
    k_end     = (k_q == K_END);
    frame_bad = xfer && (in_last != ((state_q == FILL_B) && k_end));
    reload    = (state_q == HOLD) && (!ov_q || out_ready);
  end

  always_comb begin
    k_d    = k_q;
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    a_d    = a_q;
    b_d    = b_q;
    ov_d   = ov_q;
    fe_d   = frame_bad;
    ec_d   = ec_q;
    if (xfer) begin
      k_d = (frame_bad || k_end) ? '0 : k_q + 1'b1;
      if (!frame_bad && state_q == FILL_A) sh_a_d[int'(k_q)*N +: N] = in_data;
      if (!frame_bad && state_q == FILL_B) sh_b_d[int'(k_q)*N +: N] = in_data;
    end
    if (frame_bad && ec_q != 8'hFF) ec_d = ec_q + 8'd1;
    if (reload) begin
      a_d  = sh_a_q;
      b_d  = sh_b_q;
      ov_d = 1'b1;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q    <= '0;
      sh_a_q <= '0;
      sh_b_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      ov_q   <= 1'b0;
      fe_q   <= 1'b0;
      ec_q   <= 8'd0;
    end else begin
      k_q    <= k_d;
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ov_q   <= ov_d;
      fe_q   <= fe_d;
      ec_q   <= ec_d;
    end
  end

  assign A_out     = a_q;
  assign B_out     = b_q;
  assign out_valid = ov_q;
  assign frame_err = fe_q;
  assign err_count = ec_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: frame-level reference model,
// randomized data, gaps and back-pressure, monitor-side comparison.
module tb_matrix_stream_loader;

  localparam int N = 32;
  localparam int P = 4;
  localparam int E = P * P;
  localparam int W = E * N;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic signed [N-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_last = 1'b0;
  logic                in_ready;
  logic [W-1:0]        A_out;
  logic [W-1:0]        B_out;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                frame_err;
  logic [7:0]          err_count;

  matrix_stream_loader #(.N(N), .Q(18), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .A_out     (A_out),
    .B_out     (B_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [7:0]   exp_err[$];
  logic [N-1:0] frame[$];
  int           model_ec = 0;
  logic         rand_ready_en = 1'b0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    tot_cnt++;
    $display("FAIL %s: got event, expected none", name);
  endfunction

  function automatic logic [W-1:0] pack(input logic [N-1:0] q[$], input int off);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < E; i++) r[i*N +: N] = q[off+i];
    return r;
  endfunction

  // Frame-level reference: a frame is good iff the 2*E-th element carries last
  function automatic void model_err();
    if (model_ec < 255) model_ec++;
    exp_err.push_back(8'(model_ec));
    frame.delete();
  endfunction

  function automatic void model_accept(logic [N-1:0] d, logic last);
    frame.push_back(d);
    if (frame.size() == 2*E) begin
      if (last) begin
        exp_a.push_back(pack(frame, 0));
        exp_b.push_back(pack(frame, E));
        frame.delete();
      end else begin
        model_err();
      end
    end else if (last) begin
      model_err();
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_a.size() == 0) fail("unexpected_output");
        else begin
          chk("A_out", A_out, exp_a.pop_front());
          chk("B_out", B_out, exp_b.pop_front());
        end
      end
      if (frame_err) begin
        if (exp_err.size() == 0) fail("unexpected_frame_err");
        else chk("err_count", W'(err_count), W'(exp_err.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = 1'($urandom);
    end
  end

  task automatic send(input logic [N-1:0] d, input logic last, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom);
      in_data  = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, last);
        @(posedge clk);
        #1;
        break;
      end
      if (t >= 300) begin
        tot_cnt++;
        $display("FAIL send_timeout: in_ready stuck 0, expected 1");
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_seq(input logic [N-1:0] q[$], input int last_idx, input int gap);
    foreach (q[i]) send(q[i], i == last_idx, gap);
  endtask

  task automatic wait_drain();
    for (int t = 0; ; t++) begin
      if (exp_a.size() == 0 && exp_err.size() == 0) break;
      if (t >= 2000) begin
        tot_cnt++;
        $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_a.size());
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [N-1:0] q[$];
  logic [N-1:0] f1[$];
  logic [N-1:0] f2[$];

  initial begin
    #2 reset = 1'b0;
    // reset held with random activity on the inputs
    repeat (5) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_A", A_out, '0);
      chk("rst_B", B_out, '0);
      chk("rst_err_count", W'(err_count), '0);
      chk("rst_frame_err", W'(frame_err), '0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b1;
    tick(1);

    // basic frame 1..32
    out_ready = 1'b1;
    q.delete();
    for (int i = 1; i <= 2*E; i++) q.push_back(N'(i));
    send_seq(q, 2*E-1, 0);
    chk("lat_t1_valid", W'(out_valid), '0);
    tick(1);
    chk("lat_t2_valid", W'(out_valid), W'(1));
    chk("A00", W'(A_out[N-1:0]), W'(1));
    chk("A33", W'(A_out[16*N-1:15*N]), W'(16));
    chk("B00", W'(B_out[N-1:0]), W'(17));
    chk("B33", W'(B_out[16*N-1:15*N]), W'(32));
    tick(1);
    out_ready = 1'b0;

    // back-pressure: two frames, consumer stalled
    f1.delete();
    f2.delete();
    for (int i = 0; i < 2*E; i++) begin
      f1.push_back($urandom);
      f2.push_back($urandom);
    end
    send_seq(f1, 2*E-1, 0);
    send_seq(f2, 2*E-1, 0);
    tick(3);
    chk("bp_in_ready", W'(in_ready), '0);
    chk("bp_out_valid", W'(out_valid), W'(1));
    chk("bp_hold_A", A_out, pack(f1, 0));
    chk("bp_hold_B", B_out, pack(f1, E));
    out_ready = 1'b1;
    tick(1);
    chk("bp_reload_valid", W'(out_valid), W'(1));
    chk("bp_reload_A", A_out, pack(f2, 0));
    chk("bp_reload_B", B_out, pack(f2, E));
    wait_drain();

    // early last on element 10, then a clean frame 100..131
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back($urandom);
    send_seq(q, 9, 0);
    tick(2);
    chk("early_err_count", W'(err_count), W'(1));
    q.delete();
    for (int i = 100; i < 100 + 2*E; i++) q.push_back(N'(i));
    send_seq(q, 2*E-1, 0);
    wait_drain();

    // missing last
    q.delete();
    for (int i = 0; i < 2*E; i++) q.push_back($urandom);
    send_seq(q, -1, 0);
    tick(3);
    chk("miss_err_count", W'(err_count), W'(2));
    chk("miss_no_valid", W'(out_valid), '0);

    // random frames with gaps and random consumer
    rand_ready_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      q.delete();
      for (int i = 0; i < 2*E; i++) q.push_back($urandom);
      send_seq(q, (f == 2) ? int'($urandom_range(2*E-2, 0)) : 2*E-1, 3);
    end
    tick(2);
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // saturation of the error counter
    for (int i = 0; i < 260; i++) send($urandom, 1'b1, 0);
    wait_drain();
    chk("sat_err_count", W'(err_count), W'(255));

    // reset at element 20, then a gapped frame with negative values
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back($urandom);
    send_seq(q, -1, 0);
    reset = 1'b0;
    frame.delete();
    exp_a.delete();
    exp_b.delete();
    exp_err.delete();
    model_ec = 0;
    tick(2);
    chk("mid_rst_err_count", W'(err_count), '0);
    chk("mid_rst_valid", W'(out_valid), '0);
    reset = 1'b1;
    tick(1);
    q.delete();
    for (int i = 0; i < 2*E; i++) q.push_back(i[0] ? 32'hFFFC0000 : -N'($urandom_range(1000, 1)));
    send_seq(q, 2*E-1, 3);
    wait_drain();
    tick(3);

    chk("end_pending", W'(exp_a.size()), '0);
    chk("end_err_count", W'(err_count), W'(model_ec));
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
